// File: rtl/negate_arbiter.sv
// Round-robin arbiter in front of a shared two's-complement negation datapath.
// One operand is granted per cycle and its registered result is held on a valid/ready port.
module negate_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_ovf,
  input  logic                   rsp_ready,
  output logic [7:0]             ovf_cnt
);

  // state | meaning
  // IDLE  | no result held, free to accept an operand
  // HOLD  | result held on the response port until rsp_ready
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  logic [0:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign can_accept = (state == ST_IDLE) | ((state == ST_HOLD) & rsp_ready);
  assign xfer       = can_accept & found;
  assign rsp_valid  = (state == ST_HOLD);
  assign sel_data   = req_data[int'(grant_idx)*WIDTH +: WIDTH];

  // First valid requester at or after ptr, wrapping; ptr is always < N_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // Gated by rst_n so nothing looks accepted while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (xfer && rst_n) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
    end else if (xfer) begin
      state    <= ST_HOLD;
      rsp_data <= ~sel_data + WIDTH'(1);
      rsp_id   <= grant_idx;
      rsp_ovf  <= (sel_data == MOST_NEG);
      ptr      <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
    end else if (state == ST_HOLD && rsp_ready) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_ovf && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_negate_arbiter.sv
// Self-checking bench for negate_arbiter: bench-side grant/response scoreboard
// plus a table of arithmetic corners and hand-written multi-cycle sequences.
module tb_negate_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ovf;
  logic           rsp_ready;
  logic [7:0]     ovf_cnt;

  negate_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       ovf;
  } rsp_t;

  typedef struct {
    logic [7:0] op;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  rsp_t       sb[$];
  logic [1:0] m_ptr;
  logic       m_hold;
  logic [7:0] m_cnt;

  // Reference model of grant order and response port, sampled mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    logic         found;
    logic [1:0]   gi;
    logic [7:0]   op;
    rsp_t         e;
    int           idx;
    if (!rst_n) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      m_ptr  = '0;
      m_hold = 1'b0;
      m_cnt  = '0;
      sb.delete();
    end else begin
      exp_gnt = '0;
      found   = 1'b0;
      gi      = '0;
      for (int k = 0; k < N; k++) begin
        idx = (int'(m_ptr) + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          gi    = 2'(idx);
        end
      end
      if (found && (!m_hold || rsp_ready)) exp_gnt[gi] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_gnt));
      check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
      check("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
      if (m_hold) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          check("sb_data", 32'(rsp_data), 32'(sb[0].data));
          check("sb_id", 32'(rsp_id), 32'(sb[0].id));
          check("sb_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
          if (rsp_ready) begin
            if (sb[0].ovf && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            void'(sb.pop_front());
          end
        end
      end
      if (exp_gnt != '0) begin
        op     = req_data[int'(gi)*W +: W];
        e.data = 8'(9'd256 - {1'b0, op});
        e.id   = gi;
        e.ovf  = (op == 8'h80);
        sb.push_back(e);
        m_ptr  = (gi == 2'd3) ? 2'd0 : gi + 2'd1;
        m_hold = 1'b1;
      end else if (m_hold && rsp_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d);
    req_data[i*W +: W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{op: 8'h00, exp_data: 8'h00, exp_ovf: 1'b0};
    tbl[1] = '{op: 8'h80, exp_data: 8'h80, exp_ovf: 1'b1};
    tbl[2] = '{op: 8'h7F, exp_data: 8'h81, exp_ovf: 1'b0};
    tbl[3] = '{op: 8'hFF, exp_data: 8'h01, exp_ovf: 1'b0};
    tbl[4] = '{op: 8'h01, exp_data: 8'hFF, exp_ovf: 1'b0};
    tbl[5] = '{op: 8'h05, exp_data: 8'hFB, exp_ovf: 1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Sweep every bit pattern through requester 2.
    req_valid = 4'b0100;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x;
      x = 8'(8'h80 + v);
      set_req(2, x);
      tick();
      check("sweep_data", 32'(rsp_data), 32'(8'(9'd256 - {1'b0, x})));
      check("sweep_id", 32'(rsp_id), 32'd2);
      check("sweep_ovf", 32'(rsp_ovf), 32'(x == 8'h80));
    end
    req_valid = '0;
    tick(); tick();
    check("sweep_ovf_cnt", 32'(ovf_cnt), 32'd1);

    // Hold a result, then reset asynchronously in the middle of the cycle.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_req(3, 8'h33);
    tick();
    req_valid = '0;
    tick();
    check("hold_data", 32'(rsp_data), 32'hCD);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rsp_id", 32'(rsp_id), 32'd0);
    check("async_rsp_data", 32'(rsp_data), 32'd0);
    check("async_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd0);
    tick();

    // Release with all requesters valid: strict rotation from requester 0.
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 * i + 1));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    tick();

    // Arithmetic corners through requester 1, one result per cycle.
    req_valid = 4'b0010;
    foreach (tbl[i]) begin
      set_req(1, tbl[i].op);
      tick();
      check("tbl_data", 32'(rsp_data), 32'(tbl[i].exp_data));
      check("tbl_ovf", 32'(rsp_ovf), 32'(tbl[i].exp_ovf));
      check("tbl_id", 32'(rsp_id), 32'd1);
    end
    req_valid = '0;
    tick();

    // Backpressure, then a back-to-back load on the releasing edge.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 8'h05);
    tick();
    req_valid = 4'b0010;
    set_req(1, 8'h10);
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 32'(rsp_data), 32'hFB);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("b2b_valid", 32'(rsp_valid), 32'd1);
    check("b2b_data", 32'(rsp_data), 32'hF0);
    check("b2b_id", 32'(rsp_id), 32'd1);
    req_valid = '0;
    tick();

    // Park ptr at 1, then only requesters 0 and 3 valid.
    req_valid = 4'b0001;
    set_req(0, 8'h02);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1001;
    set_req(3, 8'h03);
    tick();
    check("skip_first_id", 32'(rsp_id), 32'd3);
    req_valid = 4'b0001;
    tick();
    check("skip_second_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    tick(); tick();

    // Overflow counter saturation.
    req_valid = 4'b0010;
    set_req(1, 8'h80);
    for (int k = 0; k < 260; k++) begin
      tick();
      check("sat_data", 32'(rsp_data), 32'h80);
      check("sat_ovf", 32'(rsp_ovf), 32'd1);
    end
    req_valid = '0;
    tick(); tick();
    check("sat_ovf_cnt", 32'(ovf_cnt), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
